// File: rtl/expr_emitter_if.sv
// Character stream carried from the expression emitter to a byte consumer.
//   out_char  : ASCII character presented by the emitter
//   out_valid : out_char holds a character
//   out_ready : consumer takes the character on a rising edge with out_valid
//   out_last  : presented character closes the expression
// master = emitter side, slave = consumer side.
interface expr_emitter_if;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output out_char,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_char,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/expr_emitter.sv
// Serializes a packed arithmetic-expression descriptor into ASCII characters,
// one character per accepted handshake on the stream interface.
// Ports:
//   clk, clr            : clock (rising edge), asynchronous active-high reset
//   start               : emit request, only sampled while idle
//   n_terms             : number of digit terms (1..MAX_TERMS)
//   digits              : term i value at digits[4i+3:4i] (0..9)
//   ops                 : operator after term i, 0='+' 1='*'
//   paren_en            : emit one parenthesis pair
//   paren_lo, paren_hi  : term preceded by '(' / followed by ')'
//   bus                 : character stream (out_char/out_valid/out_ready/out_last)
//   busy                : descriptor accepted and not yet finished
//   done                : one-cycle pulse after the final character is taken
//   err                 : one-cycle pulse when the latched descriptor is rejected
module expr_emitter #(
  parameter int MAX_TERMS = 8,
  parameter int IW        = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [IW-1:0]          n_terms,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  input  logic                   paren_en,
  input  logic [IW-1:0]          paren_lo,
  input  logic [IW-1:0]          paren_hi,
  expr_emitter_if.master         bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  // Index space padded to a power of two so that a term index of IW bits
  // addresses every table entry without width adaptation.
  localparam int            DEPTH = 2**IW;
  localparam logic [IW-1:0] MAX_N = IW'(MAX_TERMS);
  localparam logic [IW-1:0] ONE   = IW'(1);

  typedef enum logic [2:0] {IDLE, VALIDATE, OPEN, DIGIT, CLOSE, OP, FIN} state_t;

  state_t state_q, state_d;

  logic [IW-1:0]          n_q;
  logic [4*MAX_TERMS-1:0] digits_q;
  logic [MAX_TERMS-2:0]   ops_q;
  logic                   pen_q;
  logic [IW-1:0]          lo_q;
  logic [IW-1:0]          hi_q;
  logic [IW-1:0]          idx_q;

  logic [3:0]       dig_arr [DEPTH];
  logic [DEPTH-1:0] ops_ext;
  logic             desc_ok;
  logic             emitting;
  logic             hs;
  logic [IW-1:0]    last_idx;
  logic [IW-1:0]    next_idx;
  logic             at_last;

  logic [7:0] char_c;
  logic       valid_c;
  logic       last_c;

  function automatic logic [7:0] op_char(input logic mul);
    return mul ? 8'h2A : 8'h2B;
  endfunction

  for (genvar g = 0; g < DEPTH; g++) begin : g_dig
    if (g < MAX_TERMS) begin : g_in
      assign dig_arr[g] = digits_q[4*g +: 4];
    end else begin : g_pad
      assign dig_arr[g] = 4'h0;
    end
  end

  assign ops_ext  = {{(DEPTH-MAX_TERMS+1){1'b0}}, ops_q};
  assign emitting = (state_q == OPEN) || (state_q == DIGIT) ||
                    (state_q == CLOSE) || (state_q == OP);
  assign hs       = emitting && bus.out_ready;
  assign last_idx = n_q - ONE;
  assign next_idx = idx_q + ONE;
  assign at_last  = (idx_q == last_idx);

  // Descriptor check on the latched copy; digits beyond n_terms are ignored.
  always_comb begin
    desc_ok = 1'b1;
    if (n_q == '0 || n_q > MAX_N) desc_ok = 1'b0;
    for (int t = 0; t < DEPTH; t++) begin
      if (IW'(t) < n_q && dig_arr[t] > 4'd9) desc_ok = 1'b0;
    end
    if (pen_q && !(lo_q <= hi_q && hi_q < n_q)) desc_ok = 1'b0;
  end

  // Descriptor capture stage: inputs are frozen at start acceptance
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      n_q      <= '0;
      digits_q <= '0;
      ops_q    <= '0;
      pen_q    <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else if (state_q == IDLE && start) begin
      n_q      <= n_terms;
      digits_q <= digits;
      ops_q    <= ops;
      pen_q    <= paren_en;
      lo_q     <= paren_lo;
      hi_q     <= paren_hi;
    end
  end

  // Term index: only advances when an operator is consumed
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      idx_q <= '0;
    end else if (state_q == IDLE && start) begin
      idx_q <= '0;
    end else if (state_q == OP && hs) begin
      idx_q <= next_idx;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Outputs decode directly from state so that clr drops them at once
  // and backpressure keeps them stable for free.
  always_comb begin
    state_d = state_q;
    char_c  = 8'h00;
    valid_c = 1'b0;
    last_c  = 1'b0;
    busy    = (state_q != IDLE);
    done    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = VALIDATE;
      end
      VALIDATE: begin
        if (!desc_ok) begin
          err     = 1'b1;
          state_d = IDLE;
        end else if (pen_q && lo_q == '0) begin
          state_d = OPEN;
        end else begin
          state_d = DIGIT;
        end
      end
      OPEN: begin
        char_c  = 8'h28;
        valid_c = 1'b1;
        if (hs) state_d = DIGIT;
      end
      DIGIT: begin
        char_c  = 8'h30 + {4'h0, dig_arr[idx_q]};
        valid_c = 1'b1;
        // A closing paren after the last digit takes over the last flag.
        last_c  = at_last && !(pen_q && idx_q == hi_q);
        if (hs) begin
          if (pen_q && idx_q == hi_q) state_d = CLOSE;
          else if (!at_last)          state_d = OP;
          else                        state_d = FIN;
        end
      end
      CLOSE: begin
        char_c  = 8'h29;
        valid_c = 1'b1;
        last_c  = at_last;
        if (hs) state_d = at_last ? FIN : OP;
      end
      OP: begin
        char_c  = op_char(ops_ext[idx_q]);
        valid_c = 1'b1;
        if (hs) state_d = (pen_q && next_idx == lo_q) ? OPEN : DIGIT;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_char  = char_c;
  assign bus.out_valid = valid_c;
  assign bus.out_last  = last_c;

endmodule

// File: doc/expr_emitter.md
Name: expr_emitter

Overview:
Transmit-side counterpart of the expression-string recognizer. The emitter takes a packed description of an arithmetic expression and serializes it as ASCII characters, one per accepted handshake. The expression uses single decimal digits, '+'/'*' operators and at most one non-nested parenthesis pair. Every string it emits is, by construction, accepted by the recognizer (recognizer out=1 after the last char). It feeds recognizer benches and any downstream byte consumer.

Parameters:
MAX_TERMS, 8, maximum number of digit terms per expression (2..15)
IW, 4, width of n_terms, paren_lo and paren_hi fields; must satisfy 2^IW > MAX_TERMS

Ports:
clk  input  1  clock, rising edge
clr  input  1  asynchronous active-high reset
start  input  1  request to emit; sampled only in IDLE
n_terms  input  IW  number of digit terms, legal range 1..MAX_TERMS
digits  input  4*MAX_TERMS  term i value at digits[4i+3:4i], legal 0..9
ops  input  MAX_TERMS-1  operator after term i: 0='+', 1='*'
paren_en  input  1  emit one parenthesis pair
paren_lo  input  IW  term index preceded by '('
paren_hi  input  IW  term index followed by ')'
out_char  output  8  ASCII character
out_valid  output  1  out_char is valid
out_ready  input  1  consumer accepts char when out_valid&&out_ready at a rising edge
out_last  output  1  current char is the final char of the expression
busy  output  1  high from start acceptance until the done pulse
done  output  1  one-cycle pulse after the last char is accepted
err  output  1  one-cycle pulse, descriptor rejected

Behaviour:
- Reset (clr=1, async): state=IDLE. out_char=0, out_valid=0, out_last=0, busy=0, done=0, err=0. The term index and latched descriptor are cleared.
- Reset mid-emission aborts immediately. out_valid drops asynchronously. No done pulse. After clr releases, the next start is accepted normally.
- Descriptor registers: in IDLE, start=1 latches all inputs at the edge. Later input changes are ignored until the block returns to IDLE.
- Validation is performed on the latched copy in the VALIDATE state. The descriptor is rejected if any of the following holds:
  - n_terms==0 or n_terms>MAX_TERMS
  - any digit at index <n_terms is >9
  - paren_en=1 and not (paren_lo<=paren_hi<n_terms)
- Digits and ops beyond n_terms are don't-care.
- Reject: err=1 for exactly one cycle, then IDLE. No chars are emitted. busy is high during VALIDATE only.
- States: IDLE, VALIDATE, OPEN, DIGIT, CLOSE, OP, FIN.
  - IDLE -> VALIDATE on start.
  - VALIDATE -> OPEN if paren_en && paren_lo==0, else -> DIGIT (index i=0).
  - OPEN: out_char="(" (8'h28). Advance to DIGIT on handshake.
  - DIGIT: out_char="0"+digit[i]. On handshake:
    - -> CLOSE if paren_en && i==paren_hi
    - else -> OP if i<n_terms-1
    - else -> FIN
  - CLOSE: out_char=")" (8'h29). On handshake -> OP if i<n_terms-1, else -> FIN.
  - OP: out_char = ops[i] ? "*"(8'h2A) : "+"(8'h2B). On handshake: i<=i+1, then -> OPEN if paren_en && i+1==paren_lo, else -> DIGIT.
  - FIN: done=1 for one cycle, busy<=0, then IDLE.
- out_valid=1 exactly in OPEN/DIGIT/CLOSE/OP. There are no bubbles between chars: a handshake at edge k presents the next char in the cycle after edge k.
- Latency: start accepted at edge k. VALIDATE occupies cycle k..k+1. The first char is valid after edge k+1. A new start is accepted at the earliest the edge after the done pulse.
- Backpressure: while out_valid&&!out_ready, out_char, out_last and state hold stable. This can continue indefinitely.
- out_last=1 only on the final char: the last DIGIT, or the CLOSE following it when paren_hi==n_terms-1.
- Char count per expression = 2*n_terms-1 + 2*paren_en.
- start asserted while busy is ignored (no queuing, no err).
- out_ready is ignored when out_valid=0.

Test Plan:
1. n_terms=2, digits={2,1}, ops[0]=0, paren_en=0, out_ready=1 -> "1","+","2" on 3 consecutive cycles starting 2 cycles after start. out_last on "2", done the cycle after, recognizer out=1.
2. n_terms=3, digits=3,4,5, ops=[1,0], paren_en=1, lo=1, hi=2 -> "3*(4+5)", 7 chars, out_last on ")".
3. Same as scenario 2 with out_ready toggling 1,0,0,1,... -> out_char stable during stalls; identical 7-char sequence; no duplicates or drops.
4. n_terms=1, digit 7, paren_en=1, lo=hi=0 -> "(7)". Then n_terms=2 with digit[1]=10 -> err pulse one cycle, out_valid never rises, busy low 2 cycles after start.
5. paren_en=1, lo=2, hi=1 -> err. n_terms=0 -> err. n_terms=MAX_TERMS=8, all digits 9, ops all 1 -> "9*9*9*9*9*9*9*9", 15 chars.
6. clr pulsed after the 3rd char of scenario 2 -> all outputs 0 immediately, no done. Scenario 1 then starts cleanly and emits "1+2".
